// File: rtl/conv_weight_bank.sv
// rtl/conv_weight_bank.sv - parametrised int8 conv kernel/bias store with req/valid kernel fetch
module conv_weight_bank #(
    parameter int  KSIZE     = 5,
    parameter int  NUM_OC    = 6,
    parameter int  NUM_IC    = 1,
    parameter int  WW        = 8,
    parameter int  BW        = 16,
    parameter      INIT_FILE = "",
    localparam int KK        = KSIZE * KSIZE,
    localparam int DEPTH     = NUM_OC * NUM_IC * KK,
    localparam int OCW       = (NUM_OC > 1) ? $clog2(NUM_OC) : 1,
    localparam int ICW       = (NUM_IC > 1) ? $clog2(NUM_IC) : 1,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int DW        = (WW > BW) ? WW : BW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             weight_req,
    input  logic [OCW-1:0]   oc_idx,
    input  logic [ICW-1:0]   ic_idx,
    input  logic             wr_en,
    input  logic             wr_bias,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    output logic [KK*WW-1:0] weights,
    output logic [BW-1:0]    bias,
    output logic             weight_valid,
    output logic             busy,
    output logic             idx_err
);

    // Word counter must be able to hold KK (the "all addresses issued" value).
    localparam int            JW   = (KK > 1) ? $clog2(KK + 1) : 1;
    localparam logic [JW-1:0] KK_J = JW'(KK);
    localparam logic [JW-1:0] LAST_J = JW'(KK - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [JW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [OCW-1:0]    oc_q;
    logic [ICW-1:0]    ic_q;
    logic              rd_vld_q;
    logic [JW-1:0]     rd_slot_q;
    logic              idx_err_q, idx_err_d;
    logic [KK*WW-1:0]  weights_q;
    logic [BW-1:0]     bias_q;

    // Storage: weight array maps to block RAM, bias array is small.
    logic [WW-1:0]     wmem [DEPTH];
    logic [BW-1:0]     bmem [NUM_OC];
    logic [WW-1:0]     rd_data_q;
    logic [BW-1:0]     bias_sh_q;
    logic [KK*WW-1:0]  shadow_q;
    logic [KK*WW-1:0]  kernel_full;

    logic              req_ok;
    logic              accept;
    logic              commit;
    logic              rd_en;
    logic              bias_rd_en;
    logic              last_capture;
    logic [AW-1:0]     rd_addr;
    logic              wr_w_ok;
    logic              wr_b_ok;

    assign req_ok       = (int'(oc_idx) < NUM_OC) && (int'(ic_idx) < NUM_IC);
    assign rd_en        = (state_q == S_FETCH) && (rd_cnt_q < KK_J);
    assign bias_rd_en   = (state_q == S_FETCH) && (rd_cnt_q == '0);
    assign last_capture = rd_vld_q && (rd_slot_q == LAST_J);
    assign rd_addr      = AW'((int'(oc_q) * NUM_IC + int'(ic_q)) * KK + int'(rd_cnt_q));
    assign wr_w_ok      = wr_en && !wr_bias && (int'(wr_addr) < DEPTH);
    assign wr_b_ok      = wr_en && wr_bias && (int'(wr_addr[OCW-1:0]) < NUM_OC);

    // Weight array: independent write port, registered read (old data on same-address collision).
    always_ff @(posedge clk) begin
        if (wr_w_ok) begin
            wmem[wr_addr] <= wr_data[WW-1:0];
        end
        if (rd_en) begin
            rd_data_q <= wmem[rd_addr];
        end
    end

    // Bias array: same write semantics; the fetched oc's bias is sampled in the first FETCH cycle.
    always_ff @(posedge clk) begin
        if (wr_b_ok) begin
            bmem[wr_addr[OCW-1:0]] <= wr_data[BW-1:0];
        end
        if (bias_rd_en) begin
            bias_sh_q <= bmem[oc_q];
        end
    end

    // Shadow kernel: each returned word lands in its slot; outputs only see it at commit.
    always_ff @(posedge clk) begin
        if (rd_vld_q) begin
            shadow_q[int'(rd_slot_q)*WW +: WW] <= rd_data_q;
        end
    end

    // The last word is still in the read register at commit, so merge it in directly.
    always_comb begin
        kernel_full = shadow_q;
        kernel_full[(KK-1)*WW +: WW] = rd_data_q;
    end

    // Next-state logic: request acceptance, word counting, abort on req drop, commit.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        idx_err_d = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (weight_req) begin
                    if (req_ok) begin
                        accept   = 1'b1;
                        rd_cnt_d = '0;
                        state_d  = S_FETCH;
                    end else begin
                        idx_err_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (!weight_req) begin
                    state_d = S_IDLE;
                end else begin
                    if (rd_cnt_q < KK_J) begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                    if (last_capture) begin
                        commit  = 1'b1;
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (!weight_req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and committed output registers; memories and shadow are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            oc_q      <= '0;
            ic_q      <= '0;
            rd_vld_q  <= 1'b0;
            rd_slot_q <= '0;
            idx_err_q <= 1'b0;
            weights_q <= '0;
            bias_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_vld_q  <= rd_en;
            rd_slot_q <= rd_cnt_q;
            idx_err_q <= idx_err_d;
            if (accept) begin
                oc_q <= oc_idx;
                ic_q <= ic_idx;
            end
            if (commit) begin
                weights_q <= kernel_full;
                bias_q    <= bias_sh_q;
            end
        end
    end

    assign weights      = weights_q;
    assign bias         = bias_q;
    assign weight_valid = (state_q == S_READY);
    assign busy         = (state_q == S_FETCH);
    assign idx_err      = idx_err_q;

endmodule
